// File: rtl/spi_frame_pkg.sv
// Shared constants, frame field map and FSM state type for the SPI frame master.
package spi_frame_pkg;

    localparam int unsigned FRAME_BITS_DEFAULT = 48;

    // Master-to-slave frame layout
    localparam int unsigned MOSI_MOTOR_X_MSB = 47;
    localparam int unsigned MOSI_MOTOR_X_LSB = 40;
    localparam int unsigned MOSI_MOTOR_Y_MSB = 39;
    localparam int unsigned MOSI_MOTOR_Y_LSB = 33;
    localparam int unsigned MOSI_ETC_MSB     = 32;
    localparam int unsigned MOSI_ETC_LSB     = 16;
    localparam int unsigned MOSI_ZERO_MSB    = 15;
    localparam int unsigned MOSI_ZERO_LSB    = 0;

    // Slave-to-master frame layout
    localparam int unsigned MISO_ENEMY_X_MSB = 47;
    localparam int unsigned MISO_ENEMY_X_LSB = 32;
    localparam int unsigned MISO_ENEMY_Y_MSB = 31;
    localparam int unsigned MISO_ENEMY_Y_LSB = 16;
    localparam int unsigned MISO_STATUS_MSB  = 15;
    localparam int unsigned MISO_STATUS_LSB  = 3;
    localparam int unsigned MISO_ZERO_MSB    = 2;
    localparam int unsigned MISO_ZERO_LSB    = 0;

    typedef struct packed {
        logic [7:0]  motor_x;
        logic [6:0]  motor_y;
        logic [16:0] etc;
        logic [15:0] zero;
    } mosi_frame_t;

    typedef struct packed {
        logic [15:0] enemy_x;
        logic [15:0] enemy_y;
        logic [12:0] status;
        logic [2:0]  zero;
    } miso_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_frame_master_sclk_gen.sv
// Mode-0 SCLK generator: toggles every CLK_DIV clk cycles while enabled, first edge a rise.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_c;

    // Ticks flag the clk edge on which sclk is about to change level
    assign tick_c      = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign rise_tick_c = tick_c && !sclk;
    assign fall_tick_c = tick_c && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (tick_c) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// Mode-0 SPI master running one fixed-length full-duplex frame per start request.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int unsigned CS_SETUP   = 4,
    parameter int unsigned CS_HOLD    = 4,
    parameter int unsigned GAP        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_frame,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic                  rx_valid,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned DLY_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP) + 1);

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_BITS-1:0] rx_frame_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic                  cs_d, mosi_d, busy_d, done_d, rx_valid_d;
    logic                  sclk_en_c, rise_tick_c, fall_tick_c;

    assign sclk_en_c = (state_q == XFER);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (reset),
        .en         (sclk_en_c),
        .sclk       (sclk),
        .rise_tick_c(rise_tick_c),
        .fall_tick_c(fall_tick_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        bit_cnt_d  = bit_cnt_q;
        dly_d      = dly_q;
        cs_d       = cs;
        mosi_d     = mosi;
        busy_d     = busy;
        done_d     = 1'b0;
        rx_frame_d = rx_frame;
        rx_valid_d = rx_valid;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sh_d    = tx_frame;
                    mosi_d     = tx_frame[FRAME_BITS-1];
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    rx_valid_d = 1'b0;
                    bit_cnt_d  = '0;
                    dly_d      = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (dly_q == DLY_W'(CS_SETUP - 1)) begin
                    dly_d   = '0;
                    state_d = XFER;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            XFER: begin
                if (rise_tick_c) begin
                    rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], miso};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                // Last fall ends the transfer; mosi keeps the final bit through HOLD
                if (fall_tick_c) begin
                    if (bit_cnt_q == BIT_W'(FRAME_BITS)) begin
                        dly_d   = '0;
                        state_d = HOLD;
                    end else begin
                        tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = tx_sh_q[FRAME_BITS-2];
                    end
                end
            end
            HOLD: begin
                if (dly_q == DLY_W'(CS_HOLD - 1)) begin
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    done_d     = 1'b1;
                    rx_frame_d = rx_sh_q;
                    rx_valid_d = 1'b1;
                    dly_d      = '0;
                    state_d    = spi_frame_pkg::GAP;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            spi_frame_pkg::GAP: begin
                if (dly_q == DLY_W'(GAP - 1)) begin
                    busy_d  = 1'b0;
                    dly_d   = '0;
                    state_d = IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            dly_q     <= '0;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_frame  <= '0;
            rx_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            dly_q     <= dly_d;
            cs        <= cs_d;
            mosi      <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
            rx_frame  <= rx_frame_d;
            rx_valid  <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: loopback and slave-model frames against a frame-level model.
`timescale 1ns/1ps
module tb_spi_frame_master;
    import spi_frame_pkg::*;

    localparam int unsigned FB        = 48;
    localparam int unsigned DIV       = 2;
    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned HOLD_CYC  = 2;
    localparam int unsigned GAP_CYC   = 4;
    localparam int FRAME_LEN  = 1 + SETUP_CYC + 2 * DIV * FB + HOLD_CYC + GAP_CYC;
    localparam int CS_LOW_LEN = SETUP_CYC + 2 * DIV * FB + HOLD_CYC;
    localparam int BOUND      = 1000;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [FB-1:0] tx_frame = '0;
    logic          miso;
    logic          busy, done, rx_valid, sclk, mosi, cs;
    logic [FB-1:0] rx_frame;

    logic          loopback   = 1'b1;
    logic [FB-1:0] slave_word = '0;
    logic [FB-1:0] slave_sh   = '0;
    logic          prev_cs    = 1'b1;
    logic          prev_sclk  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_frame_master #(
        .CLK_DIV   (DIV),
        .FRAME_BITS(FB),
        .CS_SETUP  (SETUP_CYC),
        .CS_HOLD   (HOLD_CYC),
        .GAP       (GAP_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_frame(tx_frame),
        .busy    (busy),
        .done    (done),
        .rx_frame(rx_frame),
        .rx_valid(rx_valid),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs      (cs)
    );

    // Mode-0 slave: loads its word when selected, shifts on each sclk fall
    assign miso = loopback ? mosi : slave_sh[FB-1];
    always @(negedge clk) begin
        if (prev_cs && !cs) slave_sh <= slave_word;
        else if (prev_sclk && !sclk && !cs) slave_sh <= {slave_sh[FB-2:0], 1'b0};
        prev_cs   <= cs;
        prev_sclk <= sclk;
    end

    task automatic run_frame(input logic [FB-1:0] tx, input int poke_start_at,
                             input int poke_tx_at, input logic [FB-1:0] poke_tx,
                             output int len, output int rises, output int done_hi,
                             output int done_bad, output int cs_falls, output int cs_rises,
                             output int cs_low);
        logic ps, pc;
        bit   fin;
        @(negedge clk);
        tx_frame = tx;
        start    = 1'b1;
        len = 0; rises = 0; done_hi = 0; done_bad = 0; cs_falls = 0; cs_rises = 0; cs_low = 0;
        ps = sclk; pc = cs; fin = 1'b0;
        while (!fin && len < BOUND) begin
            @(negedge clk);
            len++;
            start = (len == poke_start_at);
            if (len == poke_tx_at) tx_frame = poke_tx;
            if (sclk && !ps) rises++;
            if (!cs) cs_low++;
            if (!cs && pc) cs_falls++;
            if (cs && !pc) cs_rises++;
            if (done) begin
                done_hi++;
                if (!(cs && !pc)) done_bad++;
            end
            ps = sclk;
            pc = cs;
            if (!busy && len > 1) fin = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cs !== 1'b1)       begin n_errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
        n_checks++; if (sclk !== 1'b0)     begin n_errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_checks++; if (mosi !== 1'b0)     begin n_errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_frame !== '0)   begin n_errors++; $display("FAIL reset_rx_frame: got %h expected 0", rx_frame); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [FB-1:0] tx;
        int len, rises, dh, db, cf, cr, cl;
        loopback = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx = (i == 0) ? 48'hA5C3_1234_F00F : {16'($urandom), 32'($urandom)};
            run_frame(tx, 0, 0, '0, len, rises, dh, db, cf, cr, cl);
            n_checks++; if (rx_frame !== tx)   begin n_errors++; $display("FAIL loop_rx[%0d]: got %h expected %h", i, rx_frame, tx); end
            n_checks++; if (rx_valid !== 1'b1) begin n_errors++; $display("FAIL loop_rx_valid[%0d]: got %b expected 1", i, rx_valid); end
            n_checks++; if (rises != FB)       begin n_errors++; $display("FAIL loop_sclk_rises[%0d]: got %0d expected %0d", i, rises, FB); end
            n_checks++; if (dh != 1)           begin n_errors++; $display("FAIL loop_done_cycles[%0d]: got %0d expected 1", i, dh); end
            n_checks++; if (db != 0)           begin n_errors++; $display("FAIL loop_done_cs_rise[%0d]: got %0d misaligned expected 0", i, db); end
            n_checks++; if (len != FRAME_LEN)  begin n_errors++; $display("FAIL loop_frame_len[%0d]: got %0d expected %0d", i, len, FRAME_LEN); end
            n_checks++; if (cl != CS_LOW_LEN)  begin n_errors++; $display("FAIL loop_cs_low[%0d]: got %0d expected %0d", i, cl, CS_LOW_LEN); end
        end
    endtask

    task automatic test_slave();
        logic [FB-1:0] tx, r;
        int len, rises, dh, db, cf, cr, cl;
        loopback = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slave_word = (i == 0) ? 48'h0140_00F0_8008 : {16'($urandom), 32'($urandom)};
            tx = (i == 0) ? '0 : {16'($urandom), 32'($urandom)};
            run_frame(tx, 0, 0, '0, len, rises, dh, db, cf, cr, cl);
            n_checks++; if (rx_frame !== slave_word) begin n_errors++; $display("FAIL slave_rx[%0d]: got %h expected %h", i, rx_frame, slave_word); end
            if (i == 0) begin
                r = rx_frame;
                n_checks++; if (r[MISO_ENEMY_X_MSB:MISO_ENEMY_X_LSB] !== 16'h0140) begin n_errors++; $display("FAIL slave_enemy_x: got %h expected 0140", r[MISO_ENEMY_X_MSB:MISO_ENEMY_X_LSB]); end
                n_checks++; if (r[MISO_ENEMY_Y_MSB:MISO_ENEMY_Y_LSB] !== 16'h00F0) begin n_errors++; $display("FAIL slave_enemy_y: got %h expected 00f0", r[MISO_ENEMY_Y_MSB:MISO_ENEMY_Y_LSB]); end
                n_checks++; if (r[MISO_STATUS_MSB:MISO_STATUS_LSB] !== 13'h1001)   begin n_errors++; $display("FAIL slave_status: got %h expected 1001", r[MISO_STATUS_MSB:MISO_STATUS_LSB]); end
            end
        end
        loopback = 1'b1;
    endtask

    task automatic test_ignored_start();
        logic [FB-1:0] a, b;
        int len, rises, dh, db, cf, cr, cl;
        a = {16'($urandom), 32'($urandom)};
        b = ~a;
        run_frame(a, 50, 50, b, len, rises, dh, db, cf, cr, cl);
        n_checks++; if (dh != 1)          begin n_errors++; $display("FAIL ignore_done_count: got %0d expected 1", dh); end
        n_checks++; if (rx_frame !== a)   begin n_errors++; $display("FAIL ignore_rx: got %h expected %h", rx_frame, a); end
        n_checks++; if (cf != 1 || cr != 1) begin n_errors++; $display("FAIL ignore_cs_edges: got falls=%0d rises=%0d expected 1/1", cf, cr); end
        n_checks++; if (len != FRAME_LEN) begin n_errors++; $display("FAIL ignore_frame_len: got %0d expected %0d", len, FRAME_LEN); end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] tx;
        int done_at [3];
        int gap_hi [2];
        int n_done, n_acc, rxv_bad, cyc;
        logic pc, pv;
        tx = {16'($urandom), 32'($urandom)};
        done_at = '{0, 0, 0};
        gap_hi  = '{0, 0};
        n_done = 0; n_acc = 0; rxv_bad = 0; cyc = 0;
        @(negedge clk);
        tx_frame = tx;
        start    = 1'b1;
        pc = cs; pv = rx_valid;
        while (n_done < 3 && cyc < 3 * BOUND) begin
            @(negedge clk);
            cyc++;
            if (!cs && pc) begin
                n_acc++;
                if (rx_valid !== 1'b0) rxv_bad++;
                if (n_acc > 1 && pv !== 1'b1) rxv_bad++;
            end
            if (done) begin
                done_at[n_done] = cyc;
                n_done++;
            end
            if (cs && busy && n_done > 0 && n_done < 3) gap_hi[n_done-1]++;
            pc = cs;
            pv = rx_valid;
        end
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (n_done != 3) begin n_errors++; $display("FAIL b2b_done_count: got %0d expected 3", n_done); end
        n_checks++; if (done_at[1] - done_at[0] != FRAME_LEN) begin n_errors++; $display("FAIL b2b_spacing_01: got %0d expected %0d", done_at[1] - done_at[0], FRAME_LEN); end
        n_checks++; if (done_at[2] - done_at[1] != FRAME_LEN) begin n_errors++; $display("FAIL b2b_spacing_12: got %0d expected %0d", done_at[2] - done_at[1], FRAME_LEN); end
        n_checks++; if (gap_hi[0] != GAP_CYC) begin n_errors++; $display("FAIL b2b_gap_0: got %0d expected %0d", gap_hi[0], GAP_CYC); end
        n_checks++; if (gap_hi[1] != GAP_CYC) begin n_errors++; $display("FAIL b2b_gap_1: got %0d expected %0d", gap_hi[1], GAP_CYC); end
        n_checks++; if (n_acc != 3 || rxv_bad != 0) begin n_errors++; $display("FAIL b2b_rx_valid: got accepts=%0d bad=%0d expected 3/0", n_acc, rxv_bad); end
        n_checks++; if (rx_frame !== tx) begin n_errors++; $display("FAIL b2b_rx: got %h expected %h", rx_frame, tx); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_tx_change();
        logic [FB-1:0] tx;
        int len, rises, dh, db, cf, cr, cl;
        for (int i = 0; i < 2; i++) begin
            tx = (i == 0) ? '0 : {16'($urandom), 32'($urandom)};
            run_frame(tx, 0, 10, ~tx, len, rises, dh, db, cf, cr, cl);
            n_checks++; if (rx_frame !== tx)   begin n_errors++; $display("FAIL txchg_rx[%0d]: got %h expected %h", i, rx_frame, tx); end
            n_checks++; if (rx_valid !== 1'b1) begin n_errors++; $display("FAIL txchg_rx_valid[%0d]: got %b expected 1", i, rx_valid); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        @(negedge clk);
        tx_frame = {16'($urandom), 32'($urandom)};
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (cs !== 1'b1)       begin n_errors++; $display("FAIL midrst_cs: got %b expected 1", cs); end
        n_checks++; if (sclk !== 1'b0)     begin n_errors++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_frame !== '0)   begin n_errors++; $display("FAIL midrst_rx_frame: got %h expected 0", rx_frame); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rx_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0)        begin n_errors++; $display("FAIL midrst_stay_idle: got %0d active cycles expected 0", bad); end
        n_checks++; if (rx_frame !== '0) begin n_errors++; $display("FAIL midrst_rx_hold: got %h expected 0", rx_frame); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_ignored_start();
        test_back_to_back();
        test_tx_change();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
